// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register between two datapath stages (ID/EX, EX/MEM, MEM/WB).
// A beat carries a control bundle, three register indices and NUM_DATA data words.
// Upstream and downstream use a valid/ready handshake. With SKID_EN=1 a second
// (skid) entry lets in_ready come straight from a register, so there is no
// combinational path from out_ready. When no beat is presented, out_ctrl reads
// as zero, so downstream stages see a NOP bubble.
module pipe_stage_skid #(
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 8,
  parameter int SKID_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [REG_W-1:0]           in_rs,
  input  logic [REG_W-1:0]           in_rt,
  input  logic [REG_W-1:0]           in_rd,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [REG_W-1:0]           out_rs,
  output logic [REG_W-1:0]           out_rt,
  output logic [REG_W-1:0]           out_rd,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy
);

  localparam int DW     = NUM_DATA * DATA_W;
  localparam int BEAT_W = CTRL_W + 3 * REG_W + DW;

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic              alive;
  logic [BEAT_W-1:0] main_q;
  logic [BEAT_W-1:0] skid_q;
  logic [BEAT_W-1:0] in_beat;
  logic              in_fire;
  logic              out_fire;

  // A beat is packed as {ctrl, rs, rt, rd, data}.
  assign in_beat   = {in_ctrl, in_rs, in_rt, in_rd, in_data};
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state;

  // The main entry always drives the outputs. Control is masked so that a bubble is a NOP.
  assign out_ctrl = out_valid ? main_q[DW + 3*REG_W +: CTRL_W] : '0;
  assign out_rs   = main_q[DW + 2*REG_W +: REG_W];
  assign out_rt   = main_q[DW + REG_W +: REG_W];
  assign out_rd   = main_q[DW +: REG_W];
  assign out_data = main_q[DW-1:0];

  // With a skid entry, ready is purely a function of registered state.
  // Without one, ready looks through to out_ready.
  // The alive flag holds ready low during the cycle that follows a reset edge.
  generate
    if (SKID_EN != 0) begin : g_skid_ready
      assign in_ready = alive & (state != FULL);
    end else begin : g_comb_ready
      assign in_ready = alive & (out_ready | ~out_valid);
    end
  endgenerate

  // Handshake FSM: moves beats into main/skid and retires them. Reset outranks flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      alive  <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      alive <= 1'b1;
      if (flush) begin
        state <= EMPTY;
      end else begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_q <= in_beat;
              state  <= BUSY;
            end
          end
          BUSY: begin
            if (in_fire && out_fire) begin
              main_q <= in_beat;
            end else if (in_fire && (SKID_EN != 0)) begin
              skid_q <= in_beat;
              state  <= FULL;
            end else if (out_fire) begin
              state <= EMPTY;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_q <= skid_q;
              state  <= BUSY;
            end
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid. Instance A uses the default parameters with the skid
// buffer enabled. Instance B uses SKID_EN=0, DATA_W=64 and NUM_DATA=2.
// Each instance has a queue-based model of the beats it should be holding.
module tb_pipe_stage_skid;

  localparam int RW  = 5;
  localparam int CW  = 8;
  localparam int DA  = 3 * 32;
  localparam int BA  = CW + 3 * RW + DA;
  localparam int DB  = 2 * 64;
  localparam int BB  = CW + 3 * RW + DB;

  logic clk;
  logic rst_n;

  logic          flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [CW-1:0] in_ctrl_a, out_ctrl_a;
  logic [RW-1:0] in_rs_a, in_rt_a, in_rd_a, out_rs_a, out_rt_a, out_rd_a;
  logic [DA-1:0] in_data_a, out_data_a;
  logic [1:0]    occupancy_a;

  logic          flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [CW-1:0] in_ctrl_b, out_ctrl_b;
  logic [RW-1:0] in_rs_b, in_rt_b, in_rd_b, out_rs_b, out_rt_b, out_rd_b;
  logic [DB-1:0] in_data_b, out_data_b;
  logic [1:0]    occupancy_b;

  int tests = 0;
  int fails = 0;

  pipe_stage_skid #(.DATA_W(32), .NUM_DATA(3), .REG_W(RW), .CTRL_W(CW), .SKID_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl_a), .in_rs(in_rs_a), .in_rt(in_rt_a), .in_rd(in_rd_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_ctrl(out_ctrl_a), .out_rs(out_rs_a), .out_rt(out_rt_a), .out_rd(out_rd_a),
    .out_data(out_data_a), .occupancy(occupancy_a)
  );

  pipe_stage_skid #(.DATA_W(64), .NUM_DATA(2), .REG_W(RW), .CTRL_W(CW), .SKID_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl_b), .in_rs(in_rs_b), .in_rt(in_rt_b), .in_rd(in_rd_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_ctrl(out_ctrl_b), .out_rs(out_rs_b), .out_rt(out_rt_b), .out_rd(out_rd_b),
    .out_data(out_data_b), .occupancy(occupancy_b)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model state: each queue holds the beats the stage should be holding,
  // oldest first. The shown_* value is the beat that was most recently at the
  // head of the queue.
  logic [BA-1:0] qa[$];
  logic [BB-1:0] qb[$];
  logic [BA-1:0] shown_a;
  logic [BB-1:0] shown_b;
  bit alive_a, alive_b, started;

  // Model update on each rising edge; the inputs are stable here
  always @(posedge clk) begin
    bit fin, fout;
    started = 1'b1;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      alive_a = 1'b0; alive_b = 1'b0;
      shown_a = '0;   shown_b = '0;
    end else begin
      fin  = in_valid_a && alive_a && (qa.size() < 2);
      fout = (qa.size() > 0) && out_ready_a;
      if (flush_a) qa.delete();
      else begin
        if (fout) void'(qa.pop_front());
        if (fin)  qa.push_back({in_ctrl_a, in_rs_a, in_rt_a, in_rd_a, in_data_a});
      end
      alive_a = 1'b1;
      if (qa.size() > 0) shown_a = qa[0];

      fin  = in_valid_b && alive_b && ((qb.size() == 0) || out_ready_b);
      fout = (qb.size() > 0) && out_ready_b;
      if (flush_b) qb.delete();
      else begin
        if (fout) void'(qb.pop_front());
        if (fin)  qb.push_back({in_ctrl_b, in_rs_b, in_rt_b, in_rd_b, in_data_b});
      end
      alive_b = 1'b1;
      if (qb.size() > 0) shown_b = qb[0];
    end
  end

  // Every-cycle comparison of both instances against the model, on the falling edge
  always @(negedge clk) begin
    if (started) begin
      checkOutput("a.out_valid", 256'(out_valid_a), 256'(qa.size() > 0));
      checkOutput("a.in_ready",  256'(in_ready_a),  256'(alive_a && (qa.size() < 2)));
      checkOutput("a.occupancy", 256'(occupancy_a), 256'(qa.size()));
      checkOutput("a.out_ctrl",  256'(out_ctrl_a),  (qa.size() > 0) ? 256'(shown_a[DA+3*RW +: CW]) : 256'(0));
      checkOutput("a.out_rs",    256'(out_rs_a),    256'(shown_a[DA+2*RW +: RW]));
      checkOutput("a.out_rt",    256'(out_rt_a),    256'(shown_a[DA+RW +: RW]));
      checkOutput("a.out_rd",    256'(out_rd_a),    256'(shown_a[DA +: RW]));
      checkOutput("a.out_data",  256'(out_data_a),  256'(shown_a[DA-1:0]));

      checkOutput("b.out_valid", 256'(out_valid_b), 256'(qb.size() > 0));
      checkOutput("b.in_ready",  256'(in_ready_b),  256'(alive_b && ((qb.size() == 0) || out_ready_b)));
      checkOutput("b.occupancy", 256'(occupancy_b), 256'(qb.size()));
      checkOutput("b.occ_le_1",  256'(occupancy_b <= 2'd1), 256'(1));
      checkOutput("b.out_ctrl",  256'(out_ctrl_b),  (qb.size() > 0) ? 256'(shown_b[DB+3*RW +: CW]) : 256'(0));
      checkOutput("b.out_rs",    256'(out_rs_b),    256'(shown_b[DB+2*RW +: RW]));
      checkOutput("b.out_rt",    256'(out_rt_b),    256'(shown_b[DB+RW +: RW]));
      checkOutput("b.out_rd",    256'(out_rd_b),    256'(shown_b[DB +: RW]));
      checkOutput("b.out_data",  256'(out_data_b),  256'(shown_b[DB-1:0]));
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] c, input int k, input logic ordy);
    in_valid_a  = v;
    in_ctrl_a   = c;
    in_rs_a     = 5'(k);
    in_rt_a     = 5'(k + 1);
    in_rd_a     = 5'(k + 2);
    in_data_a   = {3{32'(k)}};
    out_ready_a = ordy;
    @(posedge clk);
    #1;
  endtask

  // Directed sequences on instance A, then a random stream on instance B
  initial begin
    rst_n = 1'b0;
    flush_a = 1'b0; flush_b = 1'b0;
    in_valid_a = 1'b0; in_ctrl_a = '0; in_rs_a = '0; in_rt_a = '0; in_rd_a = '0; in_data_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_ctrl_b = '0; in_rs_b = '0; in_rt_b = '0; in_rd_b = '0; in_data_b = '0; out_ready_b = 1'b1;

    // Reset held for two edges while inputs toggle randomly
    for (int i = 0; i < 2; i++) begin
      flush_a = 1'($urandom);
      applyStimulus(1'($urandom), 8'($urandom), int'($urandom_range(0, 255)), 1'($urandom));
      checkOutput("rst.out_valid", 256'(out_valid_a), 256'(0));
      checkOutput("rst.occupancy", 256'(occupancy_a), 256'(0));
      checkOutput("rst.in_ready",  256'(in_ready_a),  256'(0));
      checkOutput("rst.out_data",  256'(out_data_a),  256'(0));
    end
    flush_a = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 0, 1'b1);
    checkOutput("rel.in_ready", 256'(in_ready_a), 256'(1));

    // Streaming eight beats with out_ready high gives one beat per cycle and no bubbles
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 8'hA5, k, 1'b1);
      if (k == 0) checkOutput("str.first_word", 256'(out_data_a[31:0]), 256'(0));
      if (k == 3) checkOutput("str.word3", 256'(out_data_a[95:64]), 256'(3));
      checkOutput("str.valid", 256'(out_valid_a), 256'(1));
    end
    checkOutput("str.last_ctrl", 256'(out_ctrl_a), 256'(8'hA5));
    checkOutput("str.occ", 256'(occupancy_a), 256'(1));
    applyStimulus(1'b0, 8'h00, 0, 1'b1);
    checkOutput("str.drained", 256'(occupancy_a), 256'(0));

    // Back-pressure: beats 1 and 2 are held and beat 3 waits
    applyStimulus(1'b1, 8'hA5, 1, 1'b0);
    applyStimulus(1'b1, 8'hA5, 2, 1'b0);
    checkOutput("bp.occ_full", 256'(occupancy_a), 256'(2));
    checkOutput("bp.not_ready", 256'(in_ready_a), 256'(0));
    applyStimulus(1'b1, 8'hA5, 3, 1'b0);
    applyStimulus(1'b1, 8'hA5, 3, 1'b0);
    checkOutput("bp.stall_word", 256'(out_data_a[31:0]), 256'(1));
    checkOutput("bp.stall_rd", 256'(out_rd_a), 256'(3));
    applyStimulus(1'b1, 8'hA5, 3, 1'b1);
    checkOutput("bp.second", 256'(out_data_a[31:0]), 256'(2));
    checkOutput("bp.occ1", 256'(occupancy_a), 256'(1));
    applyStimulus(1'b1, 8'hA5, 3, 1'b1);
    checkOutput("bp.third", 256'(out_data_a[31:0]), 256'(3));
    applyStimulus(1'b0, 8'h00, 0, 1'b1);
    checkOutput("bp.empty", 256'(occupancy_a), 256'(0));

    // A flush while FULL drops both beats; the data outputs keep the old head
    applyStimulus(1'b1, 8'hA5, 16, 1'b0);
    applyStimulus(1'b1, 8'hA5, 17, 1'b0);
    flush_a = 1'b1;
    applyStimulus(1'b1, 8'hA5, 18, 1'b1);
    flush_a = 1'b0;
    checkOutput("fl.valid", 256'(out_valid_a), 256'(0));
    checkOutput("fl.ctrl", 256'(out_ctrl_a), 256'(0));
    checkOutput("fl.occ", 256'(occupancy_a), 256'(0));
    checkOutput("fl.hold", 256'(out_data_a[31:0]), 256'(16));
    // A flush that coincides with an accepted beat drops that beat too
    applyStimulus(1'b1, 8'hA5, 32, 1'b0);
    flush_a = 1'b1;
    applyStimulus(1'b1, 8'hA5, 33, 1'b0);
    flush_a = 1'b0;
    checkOutput("fl.drop_occ", 256'(occupancy_a), 256'(0));
    checkOutput("fl.drop_hold", 256'(out_data_a[31:0]), 256'(32));
    applyStimulus(1'b1, 8'h3C, 48, 1'b1);
    checkOutput("fl.next_valid", 256'(out_valid_a), 256'(1));
    checkOutput("fl.next_ctrl", 256'(out_ctrl_a), 256'(8'h3C));
    applyStimulus(1'b0, 8'h00, 0, 1'b1);
    checkOutput("fl.bubble_ctrl", 256'(out_ctrl_a), 256'(0));

    // Reset and flush on the same edge: the reset result wins
    applyStimulus(1'b1, 8'hA5, 64, 1'b0);
    rst_n = 1'b0;
    flush_a = 1'b1;
    applyStimulus(1'b1, 8'hA5, 65, 1'b1);
    checkOutput("rf.valid", 256'(out_valid_a), 256'(0));
    checkOutput("rf.occ", 256'(occupancy_a), 256'(0));
    checkOutput("rf.data", 256'(out_data_a), 256'(0));
    checkOutput("rf.rd", 256'(out_rd_a), 256'(0));
    rst_n = 1'b1;
    flush_a = 1'b0;
    applyStimulus(1'b0, 8'h00, 0, 1'b1);
    checkOutput("rf.ready", 256'(in_ready_a), 256'(1));

    // Random valid/ready traffic on the single-entry, wide-data instance
    for (int i = 0; i < 10000; i++) begin
      in_valid_b  = 1'($urandom);
      in_ctrl_b   = 8'($urandom);
      in_rs_b     = 5'($urandom);
      in_rt_b     = 5'($urandom);
      in_rd_b     = 5'($urandom);
      in_data_b   = {$urandom, $urandom, $urandom, $urandom};
      out_ready_b = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rnd.drained", 256'(occupancy_b), 256'(0));

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
